// File: rtl/ca_row_writer_fsm.sv
// Copies one CA generation (COLS words) into the next frame-buffer row per load/ack handshake,
// with registered write port, wrap/hold-when-full row policy, optional key stepping and buffer clear.
module ca_row_writer_fsm #(
  parameter  int WORD_W    = 16,
  parameter  int COLS      = 32,
  parameter  int ROWS      = 256,
  parameter  int WRAP_MODE = 0,
  parameter  int STEP_MODE = 0,
  localparam int COL_W     = $clog2(COLS),
  localparam int ROW_W     = $clog2(ROWS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   key,
  input  logic                   clear,
  input  logic [WORD_W-1:0]      word_in,
  output logic [COL_W-1:0]       col,
  output logic [ROW_W-1:0]       row,
  output logic                   ack,
  output logic                   mem_we,
  output logic [ROW_W+COL_W-1:0] mem_addr,
  output logic [WORD_W-1:0]      mem_data,
  output logic                   busy,
  output logic                   frame_full
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_ACK, S_WAIT_LOW, S_CLEAR} state_e;

  state_e                 state_q, state_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   ff_q, ff_d;
  logic                   wrote_q, wrote_d;
  logic                   key_q;
  logic                   we_q, we_d;
  logic [ROW_W+COL_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]      data_q, data_d;

  logic step_ok, last_col, clr_last;

  assign step_ok  = (STEP_MODE == 0) || (key_q && !key);
  assign last_col = (col_q == COL_W'(COLS-1));
  assign clr_last = ({row_q, col_q} == '1);

  assign frame_full = (WRAP_MODE != 0) && ff_q;
  assign row        = row_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_data   = data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clear)                      state_d = S_CLEAR;
        else if (load && frame_full)    state_d = S_ACK;
        else if (load && step_ok)       state_d = S_WRITE;
      end
      S_WRITE:    if (last_col) state_d = S_ACK;
      S_ACK:                    state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!load)    state_d = S_IDLE;
      S_CLEAR:    if (clr_last) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack  = 1'b0;
    busy = 1'b1;
    col  = '0;
    case (state_q)
      S_IDLE, S_WAIT_LOW: busy = 1'b0;
      S_ACK:              ack  = 1'b1;
      S_WRITE, S_CLEAR:   col  = col_q;
      default:            busy = 1'b1;
    endcase
  end

  // Counters and the registered write port; {row,col} doubles as the clear sweep address.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    ff_d    = ff_q;
    wrote_d = wrote_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        col_d = '0;
        if (clear)                   row_d   = '0;
        else if (load && frame_full) wrote_d = 1'b0;
        else if (load && step_ok)    wrote_d = 1'b1;
      end
      S_WRITE: begin
        we_d   = 1'b1;
        addr_d = {row_q, col_q};
        data_d = word_in;
        col_d  = col_q + COL_W'(1);
      end
      S_ACK: begin
        if (wrote_q) begin
          if ((WRAP_MODE != 0) && (row_q == ROW_W'(ROWS-1))) ff_d  = 1'b1;
          else                                              row_d = row_q + ROW_W'(1);
        end
      end
      S_CLEAR: begin
        we_d           = 1'b1;
        addr_d         = {row_q, col_q};
        data_d         = '0;
        {row_d, col_d} = {row_q, col_q} + (ROW_W+COL_W)'(1);
        if (clr_last) ff_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q   <= '0;
      row_q   <= '0;
      ff_q    <= 1'b0;
      wrote_q <= 1'b0;
      key_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      ff_q    <= ff_d;
      wrote_q <= wrote_d;
      key_q   <= key;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule
